// File: rtl/mixer_pkg.sv
// Shared constants, FSM state type and width helpers for the TDM mixer family.
package mixer_pkg;

    localparam int DEF_NCH   = 4;
    localparam int DEF_VOL_W = 4;
    localparam int DEF_ENV_W = 4;
    localparam int DEF_OUT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MAC    = 2'd1,
        S_FINISH = 2'd2
    } mix_state_e;

    // Width of one volume x envelope product.
    function automatic int prod_w(input int vol_w, input int env_w);
        return vol_w + env_w;
    endfunction

    // Averaging shift; a single channel needs no shift.
    function automatic int shift_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 0;
    endfunction

    // Accumulator width: enough headroom for NCH full-scale products.
    function automatic int acc_w(input int nch, input int vol_w, input int env_w);
        return prod_w(vol_w, env_w) + shift_w(nch);
    endfunction

endpackage

// File: rtl/mix_scale.sv
// Final scaling of a frame sum: average (shift) or saturate, then keep the top bits.
module mix_scale #(
    parameter int P     = 8,
    parameter int L     = 2,
    parameter int OUT_W = 8
) (
    input  logic [P+L-1:0] sum,
    input  logic           norm,
    output logic [OUT_W-1:0] sample,
    output logic           clip
);

    // Largest value representable in P bits, expressed at accumulator width.
    localparam logic [P+L-1:0] SAT_MAX = {(P+L){1'b1}} >> L;

    logic [P-1:0] v;

    // Pick the scaled value and clip flag for the selected mode.
    always_comb begin
        v    = '0;
        clip = 1'b0;
        if (norm) begin
            v = P'(sum >> L);
        end else if (sum > SAT_MAX) begin
            v    = '1;
            clip = 1'b1;
        end else begin
            v = P'(sum);
        end
    end

    assign sample = OUT_W'(v >> (P - OUT_W));

endmodule

// File: rtl/tdm_mixer.sv
// Time-multiplexed mixer: one shared MAC walks the channels once per sample tick.
module tdm_mixer
    import mixer_pkg::*;
#(
    parameter int NCH   = DEF_NCH,
    parameter int VOL_W = DEF_VOL_W,
    parameter int ENV_W = DEF_ENV_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_tick,
    input  logic                   norm,
    input  logic [NCH-1:0]         wave,
    input  logic [NCH-1:0]         enable,
    input  logic [NCH*VOL_W-1:0]   volume,
    input  logic [NCH*ENV_W-1:0]   env,
    output logic [OUT_W-1:0]       mixout,
    output logic                   mix_valid,
    output logic                   busy,
    output logic                   clip,
    output logic                   overrun
);

    localparam int P  = prod_w(VOL_W, ENV_W);
    localparam int L  = shift_w(NCH);
    localparam int A  = acc_w(NCH, VOL_W, ENV_W);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    mix_state_e state;
    logic [IW-1:0] idx;
    logic [A-1:0]  acc;

    // Frame snapshot: live inputs may change freely once a frame has started.
    logic [NCH-1:0]            wave_s;
    logic [NCH-1:0]            en_s;
    logic [NCH-1:0][VOL_W-1:0] vol_s;
    logic [NCH-1:0][ENV_W-1:0] env_s;
    logic                      norm_s;

    logic [NCH-1:0][P-1:0] terms;
    logic [P-1:0]          term;
    logic [OUT_W-1:0]      sample_nxt;
    logic                  clip_nxt;

    // Gated per-channel products from the snapshot.
    for (genvar g = 0; g < NCH; g++) begin : g_term
        assign terms[g] = (en_s[g] & wave_s[g]) ? P'(vol_s[g]) * P'(env_s[g]) : '0;
    end

    // Select the channel the MAC is working on this cycle.
    always_comb begin
        term = '0;
        for (int i = 0; i < NCH; i++) begin
            if (idx == IW'(i)) term = terms[i];
        end
    end

    mix_scale #(.P(P), .L(L), .OUT_W(OUT_W)) u_scale (
        .sum    (acc),
        .norm   (norm_s),
        .sample (sample_nxt),
        .clip   (clip_nxt)
    );

    // Frame FSM, snapshot capture, MAC and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            acc       <= '0;
            wave_s    <= '0;
            en_s      <= '0;
            vol_s     <= '0;
            env_s     <= '0;
            norm_s    <= 1'b0;
            mixout    <= '0;
            mix_valid <= 1'b0;
            busy      <= 1'b0;
            clip      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            mix_valid <= 1'b0;
            overrun   <= sample_tick && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (sample_tick) begin
                        wave_s <= wave;
                        en_s   <= enable;
                        vol_s  <= volume;
                        env_s  <= env;
                        norm_s <= norm;
                        acc    <= '0;
                        idx    <= '0;
                        busy   <= 1'b1;
                        state  <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= acc + A'(term);
                    if (idx == IW'(NCH - 1)) state <= S_FINISH;
                    else                     idx   <= idx + 1'b1;
                end
                S_FINISH: begin
                    mixout    <= sample_nxt;
                    clip      <= clip_nxt;
                    mix_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_mixer.sv
// Directed bench for tdm_mixer: default 4-channel build plus a 3-channel build.
module tb_tdm_mixer;

    logic clk = 1'b0;
    logic rst;

    // 4-channel, 4x4-bit, 8-bit output instance
    logic        tick, norm;
    logic [3:0]  wave, enable;
    logic [15:0] volume, env;
    logic [7:0]  mixout;
    logic        mix_valid, busy, clip, overrun;

    // 3-channel, 3x3-bit, 6-bit output instance
    logic        tick3, norm3;
    logic [2:0]  wave3, enable3;
    logic [8:0]  volume3, env3;
    logic [5:0]  mixout3;
    logic        mix_valid3, busy3, clip3, overrun3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tdm_mixer #(.NCH(4), .VOL_W(4), .ENV_W(4), .OUT_W(8)) dut4 (
        .clk(clk), .rst(rst), .sample_tick(tick), .norm(norm),
        .wave(wave), .enable(enable), .volume(volume), .env(env),
        .mixout(mixout), .mix_valid(mix_valid), .busy(busy),
        .clip(clip), .overrun(overrun)
    );

    tdm_mixer #(.NCH(3), .VOL_W(3), .ENV_W(3), .OUT_W(6)) dut3 (
        .clk(clk), .rst(rst), .sample_tick(tick3), .norm(norm3),
        .wave(wave3), .enable(enable3), .volume(volume3), .env(env3),
        .mixout(mixout3), .mix_valid(mix_valid3), .busy(busy3),
        .clip(clip3), .overrun(overrun3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Tick one instance (d=0: 4ch, d=1: 3ch) and check busy/valid timing and result.
    task automatic run_frame(input int d, input string tag, input int exp_out, input int exp_clip);
        int n;
        n = (d != 0) ? 3 : 4;
        if (d != 0) tick3 = 1'b1; else tick = 1'b1;
        step();
        tick = 1'b0;
        tick3 = 1'b0;
        for (int k = 0; k <= n; k++) begin
            chk({tag, "_busy"},  (d != 0) ? int'(busy3) : int'(busy), 1);
            chk({tag, "_early"}, (d != 0) ? int'(mix_valid3) : int'(mix_valid), 0);
            step();
        end
        chk({tag, "_valid"},  (d != 0) ? int'(mix_valid3) : int'(mix_valid), 1);
        chk({tag, "_idle"},   (d != 0) ? int'(busy3) : int'(busy), 0);
        chk({tag, "_mixout"}, (d != 0) ? int'(mixout3) : int'(mixout), exp_out);
        chk({tag, "_clip"},   (d != 0) ? int'(clip3) : int'(clip), exp_clip);
        step();
        chk({tag, "_pulse"},  (d != 0) ? int'(mix_valid3) : int'(mix_valid), 0);
        chk({tag, "_hold"},   (d != 0) ? int'(mixout3) : int'(mixout), exp_out);
    endtask

    initial begin
        rst = 1'b1;
        tick = 1'b0; norm = 1'b0; wave = '0; enable = '0; volume = '0; env = '0;
        tick3 = 1'b0; norm3 = 1'b0; wave3 = '0; enable3 = '0; volume3 = '0; env3 = '0;
        step();
        step();
        chk("rst_mixout", mixout, 0);
        chk("rst_valid", mix_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_clip", clip, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst3_mixout", mixout3, 0);
        rst = 1'b0;
        step();

        // All four at 15x15, S=900: saturating then averaging
        wave = 4'hF; enable = 4'hF; volume = 16'hFFFF; env = 16'hFFFF; norm = 1'b0;
        run_frame(0, "sat900", 255, 1);
        norm = 1'b1;
        run_frame(0, "avg900", 225, 0);

        // Only channel 2 active: 8x4 = 32; then its wave bit low gives 0
        norm = 1'b0; wave = 4'hF; enable = 4'b0100;
        volume = 16'h0800; env = 16'h0400;
        run_frame(0, "ch2", 32, 0);
        wave = 4'b1011;
        run_frame(0, "ch2_wave0", 0, 0);

        // Snapshot and overrun: ch0 10x10, volume dropped to 1 after the tick
        wave = 4'b0001; enable = 4'b0001; volume = 16'h000A; env = 16'h000A; norm = 1'b0;
        tick = 1'b1;
        step();                         // E0
        tick = 1'b0;
        volume = 16'h0001;
        step();                         // E1
        step();                         // E2
        tick = 1'b1;
        step();                         // E3: ignored tick
        tick = 1'b0;
        chk("ovr_pulse", overrun, 1);
        chk("ovr_busy", busy, 1);
        step();                         // E4
        chk("ovr_clear", overrun, 0);
        chk("ovr_novalid", mix_valid, 0);
        step();                         // E5
        chk("snap_valid", mix_valid, 1);
        chk("snap_mixout", mixout, 100);
        chk("snap_clip", clip, 0);
        tick = 1'b1;
        step();                         // E6: accepted
        tick = 1'b0;
        chk("retick_busy", busy, 1);
        chk("retick_noovr", overrun, 0);
        chk("retick_novalid", mix_valid, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("retick_wait", mix_valid, 0);
        end
        step();                         // E11
        chk("retick_valid", mix_valid, 1);
        chk("retick_mixout", mixout, 10);
        step();

        // Reset after the second MAC edge aborts the frame
        wave = 4'hF; enable = 4'hF; volume = 16'hFFFF; env = 16'hFFFF; norm = 1'b0;
        tick = 1'b1;
        step();                         // E0
        tick = 1'b0;
        step();                         // E1
        step();                         // E2
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_mixout", mixout, 0);
        chk("abort_busy", busy, 0);
        chk("abort_valid", mix_valid, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("abort_quiet", mix_valid, 0);
            chk("abort_idle", busy, 0);
        end
        run_frame(0, "post_abort", 255, 1);

        // 3-channel build, 7x7 each, S=147
        wave3 = 3'b111; enable3 = 3'b111; volume3 = 9'o777; env3 = 9'o777; norm3 = 1'b1;
        run_frame(1, "n3_avg", 36, 0);
        norm3 = 1'b0;
        run_frame(1, "n3_sat", 63, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdm_mixer.md
# tdm_mixer

Parametrised, time-multiplexed successor to the 3-input audio mixer. It mixes `NCH` gated tone/noise channels, each scaled by a per-channel volume × envelope product, into one `OUT_W`-bit sample for the PWM stage. A single shared multiplier-accumulator processes one channel per clock, once per `sample_tick`. Output scaling is runtime-selectable between averaging and saturating modes, and clip and overrun are reported.

## Interface
Parameters:
- `NCH`, 4: channel count, ≥1.
- `VOL_W`, 4: volume width per channel.
- `ENV_W`, 4: envelope width per channel.
- `OUT_W`, 8: output sample width. Constraint: `OUT_W ≤ VOL_W+ENV_W`.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: synchronous active-high reset.
- `sample_tick` in 1: start one mix frame.
- `norm` in 1: 1 = averaging mode, 0 = saturating mode.
- `wave` in NCH: per-channel square/noise bit.
- `enable` in NCH: per-channel enable.
- `volume` in NCH×VOL_W: packed; channel i at `[i*VOL_W +: VOL_W]`.
- `env` in NCH×ENV_W: packed, same layout.
- `mixout` out OUT_W: mixed sample, held between frames.
- `mix_valid` out 1: one-cycle pulse when `mixout` updates.
- `busy` out 1: frame in progress.
- `clip` out 1: last frame saturated; updates with `mix_valid`.
- `overrun` out 1: one-cycle pulse when `sample_tick` is ignored.

## Operation
Derived widths:
- Product width `P = VOL_W+ENV_W`.
- Shift `L = $clog2(NCH)`; `L = 0` when `NCH = 1`.
- Accumulator width `A = P+L`.

Per-channel term: `term_i = (enable[i] & wave[i]) ? volume_i*env_i : 0`, P bits.

FSM:
- IDLE:
  - `sample_tick=1` → snapshot `wave`, `enable`, `volume`, `env`, `norm`; clear acc; idx←0; go to MAC.
- MAC:
  - acc += term(idx) from the snapshot.
  - idx==NCH-1 → FINISH, else idx+1.
- FINISH:
  - Compute the sum S = acc.
  - norm=1: V = S >> L; clip←0.
  - norm=0: V = min(S, 2^P−1); clip←(S > 2^P−1).
  - mixout ← V[P-1 -: OUT_W].
  - mix_valid←1; go to IDLE.

Other rules:
- Live input changes after the snapshot do not affect the current frame.
- `sample_tick` seen while not in IDLE (MAC or FINISH) is ignored and pulses `overrun` on the next cycle. The frame continues unaffected.
- Reset values:
  - mixout=0, mix_valid=0, busy=0, clip=0, overrun=0.
  - State IDLE, acc=0, idx=0.
- Reset mid-frame aborts the frame: no `mix_valid`, and `mixout` is zeroed.

## Timing
Edge E0 is the edge at which `sample_tick` is sampled in IDLE.
- `busy` is high from after E0 until after E(NCH+1).
- Channel i accumulates at edge E(i+1).
- `mixout`, `clip`, and `mix_valid` are registered at E(NCH+1), so they are visible NCH+1 cycles after the tick cycle.
- `mix_valid` is high for exactly one cycle.
- The next tick is accepted no earlier than E(NCH+2). The minimum tick period is NCH+2 cycles.
- A tick in the same cycle that FINISH completes is an overrun.
- `rst` overrides `sample_tick` in the same cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `mixer_pkg`:
  - FSM state enum (IDLE, MAC, FINISH).
  - Default parameter constants.
  - Width helper functions for P, L, A.
- Sub-module `mix_scale`: combinational FINISH stage (shift/saturate, clip, top-bit slice), parametrised by P, L, OUT_W. Reused by future stereo variants.
- Everything else (snapshot registers, MAC, FSM, idx counter) lives in `tdm_mixer`.

## Test plan
Defaults unless stated: NCH=4, VOL_W=ENV_W=4, OUT_W=8, so P=8, L=2.
- All channels enabled, wave=1, vol=15, env=15, norm=0; tick → S=900. Required: mixout=255, clip=1, mix_valid 5 cycles after the tick cycle, busy high for 5 cycles.
- Same stimulus, norm=1 → mixout=225 (900>>2), clip=0.
- Only ch2 active with vol=8, env=4, others enable=0, norm=0 → mixout=32, clip=0. With ch2 wave=0 → mixout=0.
- Snapshot and overrun:
  - Tick with ch0 vol=10, env=10, others off, norm=0; change vol to 1 one cycle later → mixout=100.
  - Tick again 3 cycles after the first → overrun pulse, no extra mix_valid.
  - Tick 6 cycles after the first → accepted, result 10.
- Reset after the 2nd MAC edge → no mix_valid, mixout=0, busy=0. The next tick with the first scenario's stimulus yields 255 and clip=1.
- NCH=3, VOL_W=ENV_W=3, OUT_W=6 (P=6, L=2), all channels at 7×7, norm=1 → S=147, mixout=36. Same with norm=0 → mixout=63, clip=1.
